fifo_ctrl: RTL

Pointer and flag controller for the synchronous FIFO; it sits directly upstream of the FIFO storage array. It accepts producer `write` and consumer `read` strobes and generates the storage array's write/read addresses plus the `fifo_full`/`fifo_empty` flags that the array uses to gate its accesses. It also reports the fill level, almost-full/almost-empty thresholds and, optionally, sticky overflow/underflow errors.

---
 rtl/fifo_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO pointer/flag controller; FIFO_CTRL_ERR_EN compiles in sticky overflow/underflow
module fifo_ctrl #(
    parameter int n         = 3,
    parameter int SIZE      = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         write,
    input  logic         read,
    input  logic         clr_err,
    output logic [n-1:0] write_addr,
    output logic [n-1:0] read_addr,
    output logic         fifo_full,
    output logic         fifo_empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [n:0]   level,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [n:0] SIZE_L = (n+1)'(SIZE);
    localparam logic [n:0] AF_L   = (n+1)'(AF_THRESH);
    localparam logic [n:0] AE_L   = (n+1)'(AE_THRESH);
    localparam logic [n:0] ONE_L  = (n+1)'(1);

    logic [n:0] wr_ptr;
    logic [n:0] rd_ptr;
    logic [n:0] level_next;
    logic       wr_acc;
    logic       rd_acc;

    // Gating matches the storage array's own, so both sides agree on every accepted op.
    assign wr_acc = write & ~fifo_full;
    assign rd_acc = read & ~fifo_empty;

    always_comb begin
        level_next = level;
        if (wr_acc && !rd_acc) begin
            level_next = level + ONE_L;
        end else if (rd_acc && !wr_acc) begin
            level_next = level - ONE_L;
        end
    end

    assign write_addr = wr_ptr[n-1:0];
    assign read_addr  = rd_ptr[n-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            fifo_full    <= 1'b0;
            fifo_empty   <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE_L;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ONE_L;
            end
            level        <= level_next;
            fifo_full    <= (level_next == SIZE_L);
            fifo_empty   <= (level_next == '0);
            almost_full  <= (level_next >= AF_L);
            almost_empty <= (level_next <= AE_L);
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    // A new error in the same cycle as clr_err wins over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write && fifo_full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (read && fifo_empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst) begin
            assert (fifo_full == ((wr_ptr[n] != rd_ptr[n]) && (wr_ptr[n-1:0] == rd_ptr[n-1:0])));
            assert (fifo_empty == (wr_ptr == rd_ptr));
        end
    end
`endif

endmodule
